// File: rtl/channel_sample_demux_if.sv
// Bus bundle for channel_sample_demux: ADC/select inputs and
// per-channel sample outputs.
interface channel_sample_demux_if;
   logic        en;
   logic [3:0]  sel;
   logic [11:0] adc;
   logic [11:0] ch0;
   logic [11:0] ch1;
   logic [11:0] ch2;
   logic [11:0] ch3;
   logic [3:0]  valid;
   logic        frame;

   modport master (
      output en, sel, adc,
      input  ch0, ch1, ch2, ch3, valid, frame
   );

   modport slave (
      input  en, sel, adc,
      output ch0, ch1, ch2, ch3, valid, frame
   );
endinterface

// File: rtl/channel_sample_demux.sv
// Routes delayed ADC words to four channel registers by select tag.
// Optional 4-sample averaging per channel: define SD_AVERAGE_EN.
module channel_sample_demux #(
   parameter int LATENCY = 7
) (
   input  logic        sd_Clk,
   input  logic        sd_Rst,
   input  logic        sd_En,
   input  logic [3:0]  sd_Sel,
   input  logic [11:0] sd_Adc,
   output logic [11:0] sd_Ch0,
   output logic [11:0] sd_Ch1,
   output logic [11:0] sd_Ch2,
   output logic [11:0] sd_Ch3,
   output logic [3:0]  sd_Valid,
   output logic        sd_Frame
);

   typedef struct packed {
      logic       v;
      logic [1:0] ch;
   } tag_t;

   tag_t               sel_tag;
   tag_t [LATENCY-1:0] pipe_q;
   tag_t [LATENCY-1:0] pipe_d;
   tag_t               head;
   logic               cap;

   logic [3:0][11:0] ch_q;
   logic [3:0][11:0] ch_d;
   logic [3:0]       vld_q;
   logic [3:0]       vld_d;
   logic             frame_q;
   logic             frame_d;

   always_comb begin
      sel_tag = '0;
      unique case (1'b1)
         (sd_Sel == 4'd2):  sel_tag = '{v: 1'b1, ch: 2'd0};
         (sd_Sel == 4'd6):  sel_tag = '{v: 1'b1, ch: 2'd1};
         (sd_Sel == 4'd10): sel_tag = '{v: 1'b1, ch: 2'd2};
         (sd_Sel == 4'd13): sel_tag = '{v: 1'b1, ch: 2'd3};
         default:           sel_tag = '0;
      endcase
      if (!sd_En) sel_tag.v = 1'b0;
   end

   // Disabling flushes every stage so no stale tag survives re-enable
   always_comb begin
      pipe_d    = pipe_q;
      pipe_d[0] = sel_tag;
      for (int i = 1; i < LATENCY; i++) begin
         pipe_d[i] = pipe_q[i-1];
      end
      if (!sd_En) begin
         for (int i = 0; i < LATENCY; i++) begin
            pipe_d[i].v = 1'b0;
         end
      end
   end

   assign head = pipe_q[LATENCY-1];
   assign cap  = sd_En & head.v;

`ifdef SD_AVERAGE_EN
   logic [3:0][13:0] acc_q;
   logic [3:0][13:0] acc_d;
   logic [3:0][1:0]  cnt_q;
   logic [3:0][1:0]  cnt_d;
   logic [13:0]      sum;

   always_comb begin
      ch_d  = ch_q;
      vld_d = '0;
      acc_d = acc_q;
      cnt_d = cnt_q;
      sum   = acc_q[head.ch] + {2'b00, sd_Adc};
      if (cap) begin
         if (cnt_q[head.ch] == 2'd3) begin
            ch_d[head.ch]  = sum[13:2];
            vld_d[head.ch] = 1'b1;
            acc_d[head.ch] = '0;
            cnt_d[head.ch] = '0;
         end else begin
            acc_d[head.ch] = sum;
            cnt_d[head.ch] = cnt_q[head.ch] + 2'd1;
         end
      end
      if (!sd_En) begin
         acc_d = '0;
         cnt_d = '0;
      end
   end

   always_ff @(posedge sd_Clk or negedge sd_Rst) begin
      if (!sd_Rst) begin
         acc_q <= '0;
         cnt_q <= '0;
      end else begin
         acc_q <= acc_d;
         cnt_q <= cnt_d;
      end
   end
`else
   always_comb begin
      ch_d  = ch_q;
      vld_d = '0;
      if (cap) begin
         ch_d[head.ch]  = sd_Adc;
         vld_d[head.ch] = 1'b1;
      end
   end
`endif

   assign frame_d = vld_d[3];

   always_ff @(posedge sd_Clk or negedge sd_Rst) begin
      if (!sd_Rst) begin
         pipe_q  <= '0;
         ch_q    <= '0;
         vld_q   <= '0;
         frame_q <= 1'b0;
      end else begin
         pipe_q  <= pipe_d;
         ch_q    <= ch_d;
         vld_q   <= vld_d;
         frame_q <= frame_d;
      end
   end

   assign sd_Ch0   = ch_q[0];
   assign sd_Ch1   = ch_q[1];
   assign sd_Ch2   = ch_q[2];
   assign sd_Ch3   = ch_q[3];
   assign sd_Valid = vld_q;
   assign sd_Frame = frame_q;

endmodule

// File: tb/tb_channel_sample_demux.sv
// Scoreboard bench: three DUTs at LATENCY 7, 1 and 15 share a clock.
// Stimulus pushes expected pulses; a negedge monitor pops and compares.
module tb_channel_sample_demux;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   channel_sample_demux_if b7 ();
   channel_sample_demux_if b1 ();
   channel_sample_demux_if b15 ();

   logic        en_a;
   logic        en_b;
   logic [3:0]  sel;
   logic [11:0] val;
   logic [11:0] vh [16];

   assign b7.en   = en_a;
   assign b1.en   = en_b;
   assign b15.en  = en_b;
   assign b7.sel  = sel;
   assign b1.sel  = sel;
   assign b15.sel = sel;
   assign b7.adc  = vh[6];
   assign b1.adc  = vh[0];
   assign b15.adc = vh[14];

   // ADC model: word presented LATENCY edges after its select
   always @(posedge clk) begin
      for (int i = 15; i > 0; i--) vh[i] <= vh[i-1];
      vh[0] <= val;
   end

   channel_sample_demux #(.LATENCY(7)) u7 (
      .sd_Clk(clk), .sd_Rst(rst_n), .sd_En(b7.en),
      .sd_Sel(b7.sel), .sd_Adc(b7.adc),
      .sd_Ch0(b7.ch0), .sd_Ch1(b7.ch1),
      .sd_Ch2(b7.ch2), .sd_Ch3(b7.ch3),
      .sd_Valid(b7.valid), .sd_Frame(b7.frame)
   );

   channel_sample_demux #(.LATENCY(1)) u1 (
      .sd_Clk(clk), .sd_Rst(rst_n), .sd_En(b1.en),
      .sd_Sel(b1.sel), .sd_Adc(b1.adc),
      .sd_Ch0(b1.ch0), .sd_Ch1(b1.ch1),
      .sd_Ch2(b1.ch2), .sd_Ch3(b1.ch3),
      .sd_Valid(b1.valid), .sd_Frame(b1.frame)
   );

   channel_sample_demux #(.LATENCY(15)) u15 (
      .sd_Clk(clk), .sd_Rst(rst_n), .sd_En(b15.en),
      .sd_Sel(b15.sel), .sd_Adc(b15.adc),
      .sd_Ch0(b15.ch0), .sd_Ch1(b15.ch1),
      .sd_Ch2(b15.ch2), .sd_Ch3(b15.ch3),
      .sd_Valid(b15.valid), .sd_Frame(b15.frame)
   );

   typedef struct {
      int          due;
      int          ch;
      logic [11:0] v;
   } exp_t;

   exp_t             sb [3][$];
   logic [3:0][11:0] cur [3];
   int               lat [3];
   int               cyc = 0;
   int               n_chk = 0;
   int               n_pass = 0;
   bit               auto_exp = 1'b1;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm,
                      input logic [63:0] got,
                      input logic [63:0] want);
      n_chk++;
      if (got === want) n_pass++;
      else $display("FAIL %s: got %0d want %0d (cycle %0d)",
                    nm, got, want, cyc);
   endtask

   task automatic push(input int id, input int ch,
                       input logic [11:0] v);
      exp_t e;
      e.due = cyc + 1 + lat[id];
      e.ch  = ch;
      e.v   = v;
      sb[id].push_back(e);
   endtask

   task automatic purge(input int id);
      exp_t keep [$];
      foreach (sb[id][k]) begin
         if (sb[id][k].due < cyc + 1) keep.push_back(sb[id][k]);
      end
      sb[id] = keep;
   endtask

   task automatic mon(input int id, input logic [3:0] v,
                      input logic f,
                      input logic [3:0][11:0] ch);
      exp_t e;
      while (sb[id].size() > 0 && sb[id][0].due < cyc) begin
         e = sb[id].pop_front();
         chk($sformatf("pulse_missed_d%0d", id), cyc, e.due);
      end
      if (sb[id].size() > 0 && sb[id][0].due == cyc) begin
         e = sb[id].pop_front();
         cur[id][e.ch] = e.v;
         chk($sformatf("valid_d%0d", id), v, 4'b0001 << e.ch);
         chk($sformatf("frame_d%0d", id), f, e.ch == 3);
         chk($sformatf("chans_d%0d", id), ch, cur[id]);
      end else begin
         chk($sformatf("quiet_d%0d", id), {v, f}, 5'b0);
         chk($sformatf("hold_d%0d", id), ch, cur[id]);
      end
   endtask

   always @(negedge clk) begin
      mon(0, b7.valid, b7.frame,
          {b7.ch3, b7.ch2, b7.ch1, b7.ch0});
      mon(1, b1.valid, b1.frame,
          {b1.ch3, b1.ch2, b1.ch1, b1.ch0});
      mon(2, b15.valid, b15.frame,
          {b15.ch3, b15.ch2, b15.ch1, b15.ch0});
   end

   function automatic int chan_of(input logic [3:0] s);
      case (s)
         4'd2:    return 0;
         4'd6:    return 1;
         4'd10:   return 2;
         4'd13:   return 3;
         default: return -1;
      endcase
   endfunction

   task automatic step(input logic ea, input logic eb,
                       input logic [3:0] s,
                       input logic [11:0] v);
      int c;
      @(posedge clk);
      #1;
      en_a = ea;
      en_b = eb;
      sel  = s;
      val  = v;
      c    = chan_of(s);
      if (auto_exp && c >= 0) begin
         if (ea) push(0, c, v);
         if (eb) push(1, c, v);
         if (eb) push(2, c, v);
      end
      if (!ea) purge(0);
      if (!eb) purge(1);
      if (!eb) purge(2);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b1, 1'b0, 4'd0, 12'd0);
   endtask

   task automatic rst_check;
      chk("rst_ch_d0", {b7.ch3, b7.ch2, b7.ch1, b7.ch0}, 0);
      chk("rst_vf_d0", {b7.valid, b7.frame}, 0);
      chk("rst_ch_d1", {b1.ch3, b1.ch2, b1.ch1, b1.ch0}, 0);
      chk("rst_ch_d2", {b15.ch3, b15.ch2, b15.ch1, b15.ch0}, 0);
   endtask

   logic [3:0] rot [4];

   initial begin
      lat[0] = 7;
      lat[1] = 1;
      lat[2] = 15;
      for (int i = 0; i < 3; i++) cur[i] = '0;
      for (int i = 0; i < 16; i++) vh[i] = '0;
      rot[0] = 4'd2;
      rot[1] = 4'd6;
      rot[2] = 4'd10;
      rot[3] = 4'd13;
      en_a = 1'b0;
      en_b = 1'b0;
      sel  = '0;
      val  = '0;
      #1 rst_n = 1'b0;
      #1 rst_check();
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

`ifdef SD_AVERAGE_EN
      auto_exp = 1'b0;
      step(1, 0, 4'd2, 12'd100);
      step(1, 0, 4'd2, 12'd101);
      step(1, 0, 4'd2, 12'd102);
      step(1, 0, 4'd2, 12'd104);
      push(0, 0, 12'd101);
      for (int i = 0; i < 4; i++) step(1, 0, 4'd2, 12'd4095);
      push(0, 0, 12'd4095);
      step(1, 0, 4'd6, 12'd500);
      step(1, 0, 4'd6, 12'd500);
      idle(9);
      step(0, 0, 4'd0, 12'd0);
      step(1, 0, 4'd6, 12'd10);
      step(1, 0, 4'd6, 12'd20);
      step(1, 0, 4'd6, 12'd30);
      step(1, 0, 4'd6, 12'd40);
      push(0, 1, 12'd25);
      idle(10);
      chk("avg_ch0", b7.ch0, 12'd4095);
      chk("avg_ch1", b7.ch1, 12'd25);
`else
      // LATENCY bounds: one ch0 sample into all three DUTs
      step(1, 1, 4'd2, 12'd200);
      for (int i = 0; i < 20; i++) step(1, 1, 4'd0, 12'd0);
      chk("lat1_ch0", b1.ch0, 12'd200);
      chk("lat15_ch0", b15.ch0, 12'd200);
      step(0, 0, 4'd0, 12'd0);

      for (int r = 0; r < 3; r++) begin
         for (int k = 0; k < 4; k++) begin
            step(1, 0, rot[k], 12'(rot[k]) * 12'd100);
         end
      end
      idle(9);
      chk("rot_ch0", b7.ch0, 12'd200);
      chk("rot_ch1", b7.ch1, 12'd600);
      chk("rot_ch2", b7.ch2, 12'd1000);
      chk("rot_ch3", b7.ch3, 12'd1300);

      step(1, 0, 4'd2, 12'd222);
      step(1, 0, 4'd6, 12'd666);
      step(1, 0, 4'd5, 12'd555);
      step(1, 0, 4'd13, 12'd1313);
      idle(9);
      chk("ill_ch0", b7.ch0, 12'd222);
      chk("ill_ch1", b7.ch1, 12'd666);
      chk("ill_ch2", b7.ch2, 12'd1000);
      chk("ill_ch3", b7.ch3, 12'd1313);

      step(1, 0, 4'd2, 12'd201);
      step(1, 0, 4'd6, 12'd601);
      step(1, 0, 4'd10, 12'd1001);
      step(1, 0, 4'd13, 12'd1301);
      for (int i = 0; i < 3; i++) step(0, 0, 4'd2, 12'd9);
      step(1, 0, 4'd6, 12'd777);
      idle(10);
      chk("flush_ch0", b7.ch0, 12'd222);
      chk("flush_ch1", b7.ch1, 12'd777);

      for (int k = 0; k < 4; k++) begin
         step(1, 0, rot[k], 12'd300 + 12'(k));
      end
      @(posedge clk);
      #3 rst_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         sb[i].delete();
         cur[i] = '0;
      end
      #1 rst_check();
      idle(2);
      #2 rst_n = 1'b1;
      step(1, 0, 4'd13, 12'd999);
      idle(10);
      chk("post_rst_ch3", b7.ch3, 12'd999);
      chk("post_rst_ch0", b7.ch0, 12'd0);
`endif

      idle(18);
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("sb_left_d%0d", i), sb[i].size(), 0);
      end
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/channel_sample_demux.md
CHANNEL_SAMPLE_DEMUX -- requirements
Module: channel_sample_demux

Interface
REQ-001 SHALL have parameter LATENCY, default 7, the ADC pipeline delay in sd_Clk cycles from channel select to valid data; legal range 1..15.
REQ-002 SHALL have port sd_Clk, input, 1 bit: the single clock, shared with the channel switch and the ADC clock.
REQ-003 SHALL have port sd_Rst, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port sd_En, input, 1 bit: capture enable, driven by the same signal as the channel switch enable.
REQ-005 SHALL have port sd_Sel, input, 4 bits: analog mux select currently driven by the channel switch.
REQ-006 SHALL have port sd_Adc, input, 12 bits: ADC output word, offset binary, passed through without conversion.
REQ-007 SHALL have ports sd_Ch0, sd_Ch1, sd_Ch2 and sd_Ch3, each an output of 12 bits: latest registered sample for each channel.
REQ-008 SHALL have port sd_Valid, output, 4 bits: bit n pulses high for one cycle when sd_Chn updates.
REQ-009 SHALL have port sd_Frame, output, 1 bit: one-cycle pulse in the same cycle that sd_Valid[3] pulses.

Function
REQ-010 SHALL map sd_Sel to a channel tag each cycle: 2 maps to ch0, 6 to ch1, 10 to ch2 and 13 to ch3; any other code is tagged invalid.
REQ-011 SHALL pass each cycle's {valid, tag} through a delay line exactly LATENCY stages deep; tag valid requires sd_En=1 and a legal sd_Sel.
REQ-012 SHALL, when the delay-line output is valid with tag n, capture sd_Adc into sd_Chn on that edge and pulse sd_Valid[n] in the following cycle, coincident with the new value.
REQ-013 SHALL have a total latency from sd_Sel sample to sd_Chn update of LATENCY+1 edges.
REQ-014 SHALL assert at most one sd_Valid bit per cycle; outputs of channels not selected hold their values.
REQ-015 SHALL drop samples carrying an invalid tag silently, with no sd_Valid pulse and no change to any output.
REQ-016 SHALL, while sd_En=0, clear all delay-line valid bits synchronously, so that in-flight samples are discarded and no sd_Valid pulses are produced; sd_Chn hold their values.
REQ-017 SHALL, on sd_En going from 0 to 1, produce the first sd_Valid pulse LATENCY+1 cycles after the first enabled edge.
REQ-018 SHALL, if sd_Sel stalls on one code, capture every sample to that channel (repeated sd_Valid[n]); sd_Frame follows sd_Valid[3] only.

Reset
REQ-019 SHALL, when sd_Rst=0, immediately clear the delay line, sd_Ch0..sd_Ch3 to 12'd0, sd_Valid to 4'b0000, sd_Frame to 0 and all accumulators and counters.
REQ-020 SHALL, when reset is asserted mid-operation, discard all in-flight samples, so that no pulse appears after release until LATENCY+1 enabled cycles have elapsed.
REQ-021 SHALL give initial register values equal to the reset values.

Configuration
REQ-022 SHALL use macro SD_AVERAGE_EN to select averaging.
REQ-023 SHALL, with SD_AVERAGE_EN defined, give each channel a 14-bit accumulator and a 2-bit count; on the 4th captured sample, set sd_Chn to (accumulator + sample) >> 2, truncated, pulse sd_Valid[n], and clear the accumulator and count.
REQ-024 SHALL, with SD_AVERAGE_EN defined, cause sd_En=0 to also clear all accumulators and counts.
REQ-025 SHALL, with SD_AVERAGE_EN defined, produce one sd_Valid[n] per 4 captured samples of channel n, with the same latency as REQ-013 measured from the 4th sample.
REQ-026 SHALL, without SD_AVERAGE_EN, behave per REQ-012, with no accumulator logic synthesised.

Verification
REQ-027 SHALL cover the basic rotation: LATENCY=7, sd_Sel rotating 2,6,10,13 with sd_Adc=sel*100 delayed 7 -> sd_Ch0..3 = 200, 600, 1000, 1300, and sd_Valid pulsing 0001, 0010, 0100, 1000 with sd_Frame on the 1000 pulse, the first pulse 8 cycles after the first edge.
REQ-028 SHALL cover an illegal select: sd_Sel=5 for one cycle in the rotation -> no sd_Valid pulse 8 cycles later and all channel outputs unchanged.
REQ-029 SHALL cover the enable drop: sd_En dropped for 3 cycles mid-rotation -> no pulses during the flush and the next pulse exactly 8 cycles after re-enable.
REQ-030 SHALL cover reset mid-operation: sd_Rst pulsed low with samples in flight -> all outputs 0 immediately and no stale pulse after release.
REQ-031 SHALL cover averaging: with SD_AVERAGE_EN, ch0 samples 100, 101, 102, 104 -> sd_Ch0=101 with a single sd_Valid[0] pulse after the 4th sample.
REQ-032 SHALL cover the latency bounds: LATENCY=1 and LATENCY=15 -> sd_Ch0 updates exactly 2 and 16 cycles, respectively, after sd_Sel=2.
